lsu_wb: RTL and testbench



---
 rtl/lsu_wb_if.sv | 25 ++
 rtl/lsu_wb.sv | 182 ++++++++++++++++++
 tb/tb_lsu_wb.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_wb_if.sv
// Memory-side bus of the load/store unit: one request/acknowledge
// transaction carrying a word-aligned address, byte enables and data.
interface lsu_wb_if #(
  parameter int AW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  // LSU side: issues requests, receives ack and read data.
  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  // Memory side: observes requests, returns ack and read data.
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_wb.sv
// RV32I load/store unit: turns one load/store command into a single
// word-aligned memory transaction with byte enables and, for loads,
// writes the sign/zero-extended result to the register file.
module lsu_wb #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          is_store,
  input  logic [2:0]    funct3,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   store_data,
  input  logic [4:0]    rd_in,
  lsu_wb_if.master      mem,
  output logic [4:0]    rd,
  output logic          we,
  output logic [31:0]   indata,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e        state_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [3:0]    mem_be_q;
  logic [31:0]   mem_wdata_q;
  logic [4:0]    rd_q;
  logic          we_q;
  logic [31:0]   indata_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  // Command fields kept for the read-data path.
  logic [2:0]    funct3_q;
  logic [1:0]    off_q;
  logic [4:0]    rd_lat_q;

  // Decoded command (from the live inputs) and extended load result.
  logic          legal_d;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [31:0]   ext_d;

  // Decode the incoming command: legality, byte enables, lane-replicated store data.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    legal_d = 1'b1;
    be_d    = 4'b0000;
    wdata_d = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << addr[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_d    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data[15:0]}};
        if (addr[0]) legal_d = 1'b0;
      end
      2'b10: begin
        be_d = 4'b1111;
        if (addr[1:0] != 2'b00) legal_d = 1'b0;
      end
      default: legal_d = 1'b0;
    endcase
    // Stores only have SB/SH/SW; loads additionally lack 110.
    if (is_store && funct3[2]) legal_d = 1'b0;
    if (!is_store && (funct3 == 3'b110)) legal_d = 1'b0;
  end

  // Select the addressed lane of the read word and extend it.
  always_comb begin
    logic [31:0] shifted;
    shifted = mem.mem_rdata >> {off_q, 3'b000};
    case (funct3_q[1:0])
      2'b00:   ext_d = funct3_q[2] ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ext_d = funct3_q[2] ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: ext_d = mem.mem_rdata;
    endcase
  end

  // Control FSM with registered bus and register-file outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      rd_q        <= 5'd0;
      we_q        <= 1'b0;
      indata_q    <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      rd_lat_q    <= 5'd0;
    end else begin
      // Pulses last exactly one cycle unless re-asserted below.
      we_q   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            funct3_q <= funct3;
            off_q    <= addr[1:0];
            rd_lat_q <= rd_in;
            if (legal_d) begin
              state_q     <= REQ;
              busy_q      <= 1'b1;
              mem_req_q   <= 1'b1;
              mem_we_q    <= is_store;
              mem_addr_q  <= {addr[AW-1:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
            end else begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= 4'b0000;
            done_q    <= 1'b1;
            if (mem_we_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              // Writeback outputs are registered here so they appear in WB.
              state_q  <= WB;
              indata_q <= ext_d;
              rd_q     <= rd_lat_q;
              we_q     <= (rd_lat_q != 5'd0);
            end
          end
        end
        WB: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign rd            = rd_q;
  assign we            = we_q;
  assign indata        = indata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_lsu_wb.sv
// Scoreboard bench for lsu_wb: directed commands push expected memory
// transactions and completions; a monitor pops and compares them.
module tb_lsu_wb;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd_in;
  logic [4:0]  rd;
  logic        we;
  logic [31:0] indata;
  logic        busy;
  logic        done;
  logic        err;

  lsu_wb_if #(.AW(32)) mem_bus ();

  lsu_wb #(.AW(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .rd_in      (rd_in),
    .mem        (mem_bus.master),
    .rd         (rd),
    .we         (we),
    .indata     (indata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        chk_wdata;
  } mem_exp_t;

  typedef struct {
    string       name;
    logic        err;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] indata;
    int          cyc;
  } resp_exp_t;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Memory model configuration.
  int          ack_wait  = 0;
  logic [31:0] rdata_cfg = 32'h0;
  logic        hold_ack  = 1'b0;
  logic        late_ack  = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory responder: acks after ack_wait request cycles, drives just after the edge.
  initial begin
    int cnt;
    cnt = 0;
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (late_ack) begin
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'hFFFF_FFFF;
        late_ack          = 1'b0;
      end else if (mem_bus.mem_req && !hold_ack) begin
        if (cnt == ack_wait) begin
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = rdata_cfg;
          cnt               = 0;
        end else begin
          mem_bus.mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        mem_bus.mem_ack = 1'b0;
        cnt             = 0;
      end
    end
  end

  // Monitor: compares every acknowledged transaction and every completion.
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_bus.mem_req && mem_bus.mem_ack) begin
        if (mem_q.size() == 0) begin
          check("unexpected mem transaction", 32'd1, 32'd0);
        end else begin
          mem_exp_t m;
          m = mem_q.pop_front();
          check({m.name, " mem_we"}, 32'(mem_bus.mem_we), 32'(m.we));
          check({m.name, " mem_addr"}, mem_bus.mem_addr, m.addr);
          check({m.name, " mem_be"}, 32'(mem_bus.mem_be), 32'(m.be));
          if (m.chk_wdata) check({m.name, " mem_wdata"}, mem_bus.mem_wdata, m.wdata);
        end
      end
      if (done) begin
        if (resp_q.size() == 0) begin
          check("unexpected done", 32'd1, 32'd0);
        end else begin
          resp_exp_t r;
          r = resp_q.pop_front();
          check({r.name, " done cycle"}, 32'(cyc), 32'(r.cyc));
          check({r.name, " err"}, 32'(err), 32'(r.err));
          check({r.name, " we"}, 32'(we), 32'(r.we));
          if (r.we) begin
            check({r.name, " rd"}, 32'(rd), 32'(r.rd));
            check({r.name, " indata"}, indata, r.indata);
          end
        end
      end else begin
        if (we)  check("stray we", 32'd1, 32'd0);
        if (err) check("stray err", 32'd1, 32'd0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_req"}, 32'(mem_bus.mem_req), 32'd0);
    check({tag, " mem_we"}, 32'(mem_bus.mem_we), 32'd0);
    check({tag, " mem_addr"}, mem_bus.mem_addr, 32'd0);
    check({tag, " mem_be"}, 32'(mem_bus.mem_be), 32'd0);
    check({tag, " mem_wdata"}, mem_bus.mem_wdata, 32'd0);
    check({tag, " rd"}, 32'(rd), 32'd0);
    check({tag, " we"}, 32'(we), 32'd0);
    check({tag, " indata"}, indata, 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " err"}, 32'(err), 32'd0);
  endtask

  // Issue one command, queue its expectations, then wait for it to drain.
  task automatic issue(input string name, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r,
                       input int w, input logic [31:0] rdata,
                       input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                       input logic [31:0] exp_indata, input logic exp_err,
                       input logic exp_we, input logic poke);
    mem_exp_t  m;
    resp_exp_t e;
    bit        drained;
    @(negedge clk);
    ack_wait  = w;
    rdata_cfg = rdata;
    if (!exp_err) begin
      m.name      = name;
      m.we        = st;
      m.addr      = a & 32'hFFFF_FFFC;
      m.be        = exp_be;
      m.wdata     = exp_wdata;
      m.chk_wdata = st;
      mem_q.push_back(m);
    end
    e.name   = name;
    e.err    = exp_err;
    e.we     = exp_we;
    e.rd     = r;
    e.indata = exp_indata;
    e.cyc    = exp_err ? cyc + 1 : cyc + 2 + w;
    resp_q.push_back(e);
    is_store   = st;
    funct3     = f3;
    addr       = a;
    store_data = sd;
    rd_in      = r;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, " busy after start"}, 32'(busy), exp_err ? 32'd0 : 32'd1);
    check({name, " mem_req after start"}, 32'(mem_bus.mem_req), exp_err ? 32'd0 : 32'd1);
    if (poke) begin
      // A second legal command while busy must be ignored.
      is_store = 1'b0;
      funct3   = 3'b010;
      addr     = 32'h300;
      rd_in    = 5'd9;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    drained = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (resp_q.size() == 0 && mem_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) begin
      check({name, " completion timeout"}, 32'd1, 32'd0);
      mem_q.delete();
      resp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    is_store   = 1'b0;
    funct3     = 3'b000;
    addr       = 32'h0;
    store_data = 32'h0;
    rd_in      = 5'd0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    //     name   st  f3     addr     store_data    rd  w  rdata         be       wdata         indata        err we poke
    issue("LW",   0, 3'b010, 32'h100, 32'h0,        5,  3, 32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 1, 0);
    issue("LB",   0, 3'b000, 32'h103, 32'h0,        7,  1, 32'h80FF1234, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 1, 0);
    issue("LBU",  0, 3'b100, 32'h103, 32'h0,        8,  0, 32'h80FF1234, 4'b1000, 32'h0,        32'h00000080, 0, 1, 0);
    issue("LH",   0, 3'b001, 32'h102, 32'h0,        9,  0, 32'h80017FFF, 4'b1100, 32'h0,        32'hFFFF8001, 0, 1, 0);
    issue("LHU",  0, 3'b101, 32'h000, 32'h0,        10, 2, 32'h80017FFF, 4'b0011, 32'h0,        32'h00007FFF, 0, 1, 0);
    issue("SH",   1, 3'b001, 32'h202, 32'hAAAABEEF, 1,  0, 32'h0,        4'b1100, 32'hBEEFBEEF, 32'h0,        0, 0, 0);
    issue("SB",   1, 3'b000, 32'h001, 32'h123456A5, 2,  1, 32'h0,        4'b0010, 32'hA5A5A5A5, 32'h0,        0, 0, 0);
    issue("SW",   1, 3'b010, 32'h010, 32'h01234567, 3,  0, 32'h0,        4'b1111, 32'h01234567, 32'h0,        0, 0, 0);
    issue("LH misaligned", 0, 3'b001, 32'h101, 32'h0, 4, 0, 32'h0,       4'b0000, 32'h0,        32'h0,        1, 0, 0);
    issue("SW misaligned", 1, 3'b010, 32'h106, 32'h5, 4, 0, 32'h0,       4'b0000, 32'h0,        32'h0,        1, 0, 0);
    issue("load f3 011",   0, 3'b011, 32'h000, 32'h0, 4, 0, 32'h0,       4'b0000, 32'h0,        32'h0,        1, 0, 0);
    issue("load f3 110",   0, 3'b110, 32'h000, 32'h0, 4, 0, 32'h0,       4'b0000, 32'h0,        32'h0,        1, 0, 0);
    issue("store f3 100",  1, 3'b100, 32'h000, 32'h0, 4, 0, 32'h0,       4'b0000, 32'h0,        32'h0,        1, 0, 0);
    issue("LW x0 poke",    0, 3'b010, 32'h040, 32'h0, 0, 2, 32'h12345678, 4'b1111, 32'h0,       32'h12345678, 0, 0, 1);

    // Reset while a request is outstanding, then a late ack.
    hold_ack   = 1'b1;
    is_store   = 1'b0;
    funct3     = 3'b010;
    addr       = 32'h80;
    rd_in      = 5'd3;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre-reset mem_req", 32'(mem_bus.mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid-reset");
    reset    = 1'b0;
    late_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post-reset we", 32'(we), 32'd0);
      check("post-reset done", 32'(done), 32'd0);
      check("post-reset busy", 32'(busy), 32'd0);
    end
    hold_ack = 1'b0;

    check("mem queue drained", 32'(mem_q.size()), 32'd0);
    check("resp queue drained", 32'(resp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
